// File: rtl/case_mul_pkg.sv
// -----------------------------------------------------------------------------
// case_mul_pkg
//   Shared definitions for the case_mul_pipe_ss pipelined multiplier core.
//
//   Contents:
//     MUL_MAX_STAGE  deepest pipeline the core supports
//     mul_mode_e     operand interpretation (unsigned / two's complement)
//     mul_lat()      result latency in cycles for a given stage count,
//                    assuming no backpressure
// -----------------------------------------------------------------------------
package case_mul_pkg;

    localparam int MUL_MAX_STAGE = 8;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_e;

    // Every stage is a single register on the beat's path, so the latency
    // is the stage count itself.
    function automatic int mul_lat(input int stages);
        return stages;
    endfunction

endpackage : case_mul_pkg

// File: rtl/case_mul_pipe_stage.sv
// -----------------------------------------------------------------------------
// case_mul_pipe_stage
//   One valid-tagged pipeline register of the multiplier core. The payload
//   and its valid bit move together whenever the stage is enabled, and both
//   hold otherwise, so a stalled pipeline keeps bubbles where they are.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high clear of valid and payload
//     en         advance enable (shared by every stage of the pipeline)
//     valid_in   valid bit of the beat presented to this stage
//     data_in    payload presented to this stage
//     valid_out  registered valid bit
//     data_out   registered payload
// -----------------------------------------------------------------------------
module case_mul_pipe_stage
    import case_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    // NOTE: state is written with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking writes here would let
    // a beat skip stages depending on evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            // NOTE: clearing the payload is not needed for correctness (it is
            // don't-care while valid is low) but it keeps reset state free of
            // X; large memories would normally be left out of reset.
            data_out  <= '0;
        end else if (en) begin
            valid_out <= valid_in;
            data_out  <= data_in;
        end
    end

endmodule : case_mul_pipe_stage

// File: rtl/case_mul_pipe_ss.sv
// -----------------------------------------------------------------------------
// case_mul_pipe_ss
//   Parametrised, pipelined signed/unsigned multiplier with valid/ready flow
//   control and full backpressure, for HLS-generated case_* datapaths.
//
//   Pipeline: stage 1 registers the operands, the product is formed from the
//   stage-1 registers, and stages 2..NUM_STAGE are retiming registers that
//   carry the product. The whole pipeline advances together (adv), so latency
//   is NUM_STAGE cycles plus one per stall cycle.
//
//   Optional feature, macro HLS_MUL_ACC_EN:
//     defined   - the output adds the product into a dout_WIDTH accumulator:
//                 dout = (acc_clr ? 0 : acc) + product (wrapping). The
//                 accumulator updates when the result beat is taken, and
//                 acc_clr travels through the pipeline with its beat.
//     undefined - plain multiply; acc_clr is ignored.
//
//   Parameters:
//     ID          instance tag, no functional effect
//     NUM_STAGE   register stages / latency, 1..MUL_MAX_STAGE
//     din0_WIDTH  operand A width
//     din1_WIDTH  operand B width
//     dout_WIDTH  result width (truncated or extended product)
//     SIGNED      1 = two's complement operands, 0 = unsigned
//
//   Ports:
//     ap_clk     clock, rising edge
//     ap_rst     synchronous active-high reset; flushes in-flight beats
//     in_valid   operand beat valid
//     in_ready   core accepts a beat this cycle
//     din0       operand A
//     din1       operand B
//     acc_clr    beat starts a new accumulation (HLS_MUL_ACC_EN only)
//     out_valid  result valid
//     out_ready  consumer takes the result
//     dout       result, held while out_valid & ~out_ready
// -----------------------------------------------------------------------------
module case_mul_pipe_ss
    import case_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 26,
    parameter int SIGNED     = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int        PROD_W = din0_WIDTH + din1_WIDTH;
    // Stage payload is {clr, operands} in stage 1 and {clr, product} after;
    // both pack to PROD_W+1 bits, so every stage shares one width.
    localparam int        PAY_W  = PROD_W + 1;
    localparam mul_mode_e MODE   = (SIGNED != 0) ? MUL_SIGNED : MUL_UNSIGNED;

    // ID is only a tag; any non-negative value is accepted.
    if (NUM_STAGE < 1 || mul_lat(NUM_STAGE) > MUL_MAX_STAGE || ID < 0) begin : g_bad_cfg
        $error("case_mul_pipe_ss: NUM_STAGE must be in 1..%0d", MUL_MAX_STAGE);
    end

    // ------------------------------------------------------------------
    // Flow control: the pipeline moves whenever the output slot is empty
    // or being drained this cycle. One enable for all stages keeps
    // bubbles in place during a stall and makes latency stall-exact.
    // ------------------------------------------------------------------
    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Stage interconnect
    // ------------------------------------------------------------------
    logic             stg_v_in  [NUM_STAGE];
    logic             stg_v_out [NUM_STAGE];
    logic [PAY_W-1:0] stg_d_in  [NUM_STAGE];
    logic [PAY_W-1:0] stg_d_out [NUM_STAGE];

    logic clr_in;

`ifdef HLS_MUL_ACC_EN
    assign clr_in = acc_clr;
`else
    // Without the accumulator the clear flag has no meaning; carry a
    // constant so the stage wiring is identical in both builds.
    assign clr_in = 1'b0;
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
`endif

    // ------------------------------------------------------------------
    // Product formed from the stage-1 operand registers
    // ------------------------------------------------------------------
    logic                  op_clr;
    logic [din0_WIDTH-1:0] op_a;
    logic [din1_WIDTH-1:0] op_b;
    logic [PROD_W-1:0]     a_ext;
    logic [PROD_W-1:0]     b_ext;
    logic [PROD_W-1:0]     product;
    logic [PAY_W-1:0]      prod_pay;

    assign {op_clr, op_a, op_b} = stg_d_out[0];

    // Extending both operands to the full product width and keeping the low
    // PROD_W bits of an unsigned multiply gives the exact two's complement
    // product for sign-extended inputs, so one multiplier serves both modes.
    always_comb begin
        if (MODE == MUL_SIGNED) begin
            a_ext = {{din1_WIDTH{op_a[din0_WIDTH-1]}}, op_a};
            b_ext = {{din0_WIDTH{op_b[din1_WIDTH-1]}}, op_b};
        end else begin
            a_ext = {{din1_WIDTH{1'b0}}, op_a};
            b_ext = {{din0_WIDTH{1'b0}}, op_b};
        end
        product = a_ext * b_ext;
    end

    assign prod_pay = {op_clr, product};

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign stg_v_in[g] = in_valid;
            assign stg_d_in[g] = {clr_in, din0, din1};
        end else if (g == 1) begin : g_product
            assign stg_v_in[g] = stg_v_out[0];
            assign stg_d_in[g] = prod_pay;
        end else begin : g_retime
            assign stg_v_in[g] = stg_v_out[g-1];
            assign stg_d_in[g] = stg_d_out[g-1];
        end

        case_mul_pipe_stage #(
            .WIDTH (PAY_W)
        ) u_stage (
            .clk       (ap_clk),
            .rst       (ap_rst),
            .en        (adv),
            .valid_in  (stg_v_in[g]),
            .data_in   (stg_d_in[g]),
            .valid_out (stg_v_out[g]),
            .data_out  (stg_d_out[g])
        );
    end

    // ------------------------------------------------------------------
    // Final-stage payload and result sizing
    // ------------------------------------------------------------------
    logic [PAY_W-1:0]      fin_pay;
    logic [dout_WIDTH-1:0] result;

    if (NUM_STAGE == 1) begin : g_fin_direct
        assign fin_pay = prod_pay;
    end else begin : g_fin_reg
        assign fin_pay = stg_d_out[NUM_STAGE-1];
    end

    if (dout_WIDTH <= PROD_W) begin : g_res_trunc
        assign result = fin_pay[dout_WIDTH-1:0];
    end else begin : g_res_ext
        assign result = {{(dout_WIDTH-PROD_W){(MODE == MUL_SIGNED) & fin_pay[PROD_W-1]}},
                         fin_pay[PROD_W-1:0]};
    end

    assign out_valid = stg_v_out[NUM_STAGE-1];

    // ------------------------------------------------------------------
    // Output: dout is forced to 0 whenever no result is presented so the
    // port is deterministic after reset and between beats.
    // ------------------------------------------------------------------
`ifdef HLS_MUL_ACC_EN
    logic [dout_WIDTH-1:0] acc;
    logic [dout_WIDTH-1:0] acc_sum;

    // The sum is combinational on held registers, so dout stays stable
    // while the consumer stalls; the accumulator commits only on a take.
    assign acc_sum = (fin_pay[PROD_W] ? '0 : acc) + result;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc <= '0;
        end else if (out_valid && out_ready) begin
            acc <= acc_sum;
        end
    end

    assign dout = out_valid ? acc_sum : '0;
`else
    assign dout = out_valid ? result : '0;

    logic unused_fin_clr;
    assign unused_fin_clr = fin_pay[PROD_W];
`endif

endmodule : case_mul_pipe_ss
